// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and M-stage data access; data wins ties, aborts after TIMEOUT cycles.
// Optional MEM_ARB_PERF_CNT_EN adds perf_conflict, a saturating count of IDLE cycles with both requesters eligible.
module mem_arbiter #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [DW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [DW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          bus_err
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_conflict
`endif
);

    localparam int CW = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;

    typedef enum logic [1:0] {S_IDLE, S_IF_WAIT, S_DM_WAIT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_mem_req,   w_mem_req_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic [DW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_if_ready,  w_if_ready_nxt;
    logic          r_dm_ready,  w_dm_ready_nxt;
    logic          r_bus_err,   w_bus_err_nxt;
    logic [DW-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [DW-1:0] r_dm_rdata,  w_dm_rdata_nxt;

    logic w_if_elig;
    logic w_dm_elig;
    logic w_timeout;

    // A requester whose ready is pulsing this cycle is just being answered, not asking again.
    assign w_if_elig = if_req & ~r_if_ready;
    assign w_dm_elig = dm_req & ~r_dm_ready;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_dm_elig) begin
                    w_state_nxt = S_DM_WAIT;
                end else if (w_if_elig) begin
                    w_state_nxt = S_IF_WAIT;
                end
            end
            S_IF_WAIT, S_DM_WAIT: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ready_nxt  = 1'b0;
        w_dm_ready_nxt  = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_dm_elig) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    w_cnt_nxt       = '0;
                end else if (w_if_elig) begin
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = '0;
                    w_cnt_nxt       = '0;
                end
            end
            S_IF_WAIT, S_DM_WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack || w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_bus_err_nxt = ~mem_ack;
                    if (r_state == S_IF_WAIT) begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = mem_ack ? mem_rdata : '0;
                    end else begin
                        w_dm_ready_nxt = 1'b1;
                        w_dm_rdata_nxt = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_dm_ready  <= w_dm_ready_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign bus_err   = r_bus_err;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = dm_req & ~r_dm_ready;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf <= '0;
        end else if ((r_state == S_IDLE) && w_if_elig && w_dm_elig && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_conflict = r_perf;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios pinned with literal values, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   perf_conflict;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_conflict(perf_conflict)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: who owns the memory (-1 nobody, 0 fetch, 1 data), how many cycles the request has been up, what was latched.
    int          m_owner;
    int          m_age;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic        m_if_ready, m_dm_ready, m_err;
    logic [31:0] m_if_rdata, m_dm_rdata;
    logic [31:0] m_perf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_age = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0;
        m_if_ready = 1'b0; m_dm_ready = 1'b0; m_err = 1'b0;
        m_if_rdata = '0; m_dm_rdata = '0; m_perf = '0;
    endtask

    task automatic model_step();
        logic n_ifr, n_dmr, n_err, ie, de;
        n_ifr = 1'b0; n_dmr = 1'b0; n_err = 1'b0;
        if (m_owner >= 0) begin
            if (mem_ack || m_age == TO) begin
                if (m_owner == 0) begin
                    n_ifr = 1'b1; m_if_rdata = mem_ack ? mem_rdata : 32'h0;
                end else begin
                    n_dmr = 1'b1; m_dm_rdata = mem_ack ? mem_rdata : 32'h0;
                end
                n_err   = !mem_ack;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            ie = if_req && !m_if_ready;
            de = dm_req && !m_dm_ready;
            if (ie && de && m_perf != 32'hFFFF_FFFF) m_perf++;
            if (de) begin
                m_owner = 1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_age = 1;
            end else if (ie) begin
                m_owner = 0; m_addr = if_addr; m_we = 1'b0; m_wdata = '0; m_age = 1;
            end
        end
        m_if_ready = n_ifr; m_dm_ready = n_dmr; m_err = n_err;
    endtask

    task automatic compare_all();
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_owner >= 0});
        if (m_owner >= 0) begin
            chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ready", {31'b0, if_ready}, {31'b0, m_if_ready});
        chk("dm_ready", {31'b0, dm_ready}, {31'b0, m_dm_ready});
        chk("bus_err", {31'b0, bus_err}, {31'b0, m_err});
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("dm_rdata", dm_rdata, m_dm_rdata);
        chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~m_if_ready});
        chk("stall_mem", {31'b0, stall_mem}, {31'b0, dm_req & ~m_dm_ready});
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_conflict", perf_conflict, m_perf);
`endif
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st_cnt, hi, pulses, got;
        logic [31:0] err_seen, data_seen;
        bit resp_active;
        int resp_cnt, resp_delay;

        rst = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        model_reset();
        #2;
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_readys", {30'b0, if_ready, dm_ready}, 0);
        chk("rst_bus_err", {31'b0, bus_err}, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single fetch, ack in first mem_req cycle.
        if_req = 1; if_addr = 32'h10; settle();
        chk("A_stall_c0", {31'b0, stall_if}, 1); chk("A_memreq_c0", {31'b0, mem_req}, 0); advance();
        mem_ack = 1; mem_rdata = 32'h8C02_0004; settle();
        chk("A_memreq_c1", {31'b0, mem_req}, 1); chk("A_addr_c1", mem_addr, 32'h10);
        chk("A_stall_c1", {31'b0, stall_if}, 1); advance();
        mem_ack = 0; settle();
        chk("A_ready_c2", {31'b0, if_ready}, 1); chk("A_rdata_c2", if_rdata, 32'h8C02_0004);
        chk("A_stall_c2", {31'b0, stall_if}, 0); advance();
        if_req = 0; settle();
        chk("A_no_reissue", {31'b0, mem_req}, 0); chk("A_ready_c3", {31'b0, if_ready}, 0); advance();

        // Simultaneous requests: store first, then the fetch.
        st_cnt = 0;
        if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 1; dm_addr = 32'h54; dm_wdata = 32'd7;
        settle(); st_cnt += int'(stall_if); advance();
        mem_ack = 1; mem_rdata = 32'hDEAD_0000; settle(); st_cnt += int'(stall_if);
        chk("B_we", {31'b0, mem_we}, 1); chk("B_addr", mem_addr, 32'h54); chk("B_wdata", mem_wdata, 32'd7);
        advance();
        mem_ack = 0; dm_req = 0; dm_we = 0; settle(); st_cnt += int'(stall_if);
        chk("B_dm_ready", {31'b0, dm_ready}, 1); advance();
        mem_ack = 1; mem_rdata = 32'h0000_1234; settle(); st_cnt += int'(stall_if);
        chk("B_if_we", {31'b0, mem_we}, 0); chk("B_if_addr", mem_addr, 32'h20); advance();
        mem_ack = 0; if_req = 0; settle(); st_cnt += int'(stall_if);
        chk("B_if_ready", {31'b0, if_ready}, 1); chk("B_if_rdata", if_rdata, 32'h0000_1234);
        chk("B_stall_cycles", st_cnt, 4);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("B_perf", perf_conflict, 1);
`endif
        advance();

        // Slow memory: ack on the sixth mem_req cycle.
        dm_req = 1; dm_we = 0; dm_addr = 32'h80; settle(); advance();
        dm_req = 0; hi = 0; pulses = 0;
        for (int k = 0; k < 6; k++) begin
            mem_ack = (k == 5); mem_rdata = 32'hCAFE_0080; settle();
            if (mem_req && mem_addr == 32'h80) hi++;
            advance();
        end
        mem_ack = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            if (dm_ready) begin pulses++; chk("C_rdata", dm_rdata, 32'hCAFE_0080); end
            advance();
        end
        chk("C_stable_cycles", hi, 6); chk("C_pulses", pulses, 1);

        // Timeout with no ack.
        dm_req = 1; dm_addr = 32'h90; settle(); advance();
        dm_req = 0; hi = 0; got = 0; err_seen = 0; data_seen = 32'hFFFF_FFFF;
        for (int k = 0; k < 40 && got == 0; k++) begin
            settle();
            if (dm_ready) begin got = 1; err_seen = {31'b0, bus_err}; data_seen = dm_rdata; end
            else if (mem_req) hi++;
            advance();
        end
        chk("D_ready_seen", got, 1); chk("D_req_cycles", hi, TO);
        chk("D_bus_err", err_seen, 1); chk("D_rdata", data_seen, 0);

        // Reset in the middle of a store.
        dm_req = 1; dm_we = 1; dm_addr = 32'hA0; dm_wdata = 32'd5; settle(); advance();
        dm_req = 0; dm_we = 0; settle(); chk("E_req_before", {31'b0, mem_req}, 1); advance();
        rst = 1'b0; model_reset(); #1;
        chk("E_req_async_drop", {31'b0, mem_req}, 0);
        settle(); advance();
        rst = 1'b1; mem_ack = 1;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("E_no_ready", {30'b0, if_ready, dm_ready}, 0); advance();
        end
        mem_ack = 0;

        // Randomized traffic with a variable-latency memory.
        resp_active = 0; resp_cnt = 0; resp_delay = 0;
        for (int n = 0; n < 3000; n++) begin
            if_req   = ($urandom % 3) != 0;
            if_addr  = $urandom;
            dm_req   = ($urandom % 3) == 0;
            dm_we    = 1'($urandom % 2);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!resp_active) begin
                    resp_active = 1; resp_cnt = 0;
                    resp_delay = ($urandom % 8 == 0) ? 20 : int'($urandom % 4);
                end
                mem_ack = (resp_cnt == resp_delay);
                resp_cnt++;
            end else begin
                resp_active = 0;
                mem_ack = ($urandom % 4) == 0;
            end
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
